module_pulse_stretcher: RTL
===========================

# module_pulse_stretcher

Output-side conditioning block for board-level indicators and strobes. It converts single-cycle internal events into clean, minimum-width pulses on a physical output, with a guaranteed low gap between pulses. It queues events that arrive while a pulse is in progress and flags lost events. It sits between the core logic (e.g. SPI transaction-done, error strobes) and LED or test-point pins, mirroring what the input debouncer does for buttons.

## Interface
- HOLD_CYCLES, 4: high time of every output pulse in clk_i cycles; must be ≥1.
- GAP_CYCLES, 2: minimum low time after every pulse; must be ≥1.
- PEND_W, 2: width of the pending-event counter; PEND_MAX = 2^PEND_W − 1.
- RETRIGGER, 0: 1 = an event during HOLD reloads the hold count instead of queueing.
- clk_i  input  1  single system clock, rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- event_i  input  1  one-cycle event request, synchronous to clk_i.
- clear_ovf_i  input  1  clears overflow_o.
- stretch_o  output  1  stretched pulse to the pin; registered.
- busy_o  output  1  high whenever the state is not IDLE.
- pending_o  output  PEND_W  queued events not yet emitted.
- overflow_o  output  1  sticky; set when an event was dropped.

## Operation
- States: IDLE, HOLD, GAP. stretch_o = 1 exactly in HOLD.
- IDLE + event_i: go to HOLD and load the counter with HOLD_CYCLES−1. The event is consumed and does not enter pending.
- HOLD: decrement each cycle. At count 0, go to GAP and load GAP_CYCLES−1.
  - event_i in HOLD with RETRIGGER=0: pending += 1.
  - event_i in HOLD with RETRIGGER=1: reload HOLD_CYCLES−1; pending unchanged.
- GAP: event_i → pending += 1. At count 0, let eff = pending + event_i.
  - eff > 0: go directly to HOLD, load HOLD_CYCLES−1, pending ← eff − 1.
  - eff = 0: go to IDLE.
- Saturation:
  - A non-consumed event with pending = PEND_MAX leaves pending unchanged and sets overflow_o.
  - At GAP end with pending = PEND_MAX and event_i, one event is consumed and one added: pending stays PEND_MAX, no overflow.
- clear_ovf_i clears overflow_o. If clear and a new overflow occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-HOLD or mid-GAP):
  - state IDLE, counter 0, stretch_o 0, busy_o 0, pending_o 0, overflow_o 0.
  - Events during reset are discarded.

## Timing
- Event sampled at edge k from IDLE: stretch_o high after edge k, low after edge k+HOLD_CYCLES. Latency 1 cycle.
- Each pulse is exactly HOLD_CYCLES cycles high, followed by at least GAP_CYCLES cycles low. Back-to-back queued pulses have period HOLD_CYCLES+GAP_CYCLES.
- busy_o is decoded from the state register only, with no input-to-output combinational path.
- pending_o and overflow_o update on the same edge as the event that changes them.
- Counter width is $clog2(max(HOLD_CYCLES, GAP_CYCLES)), minimum 1. The counter never wraps: it is reloaded at each state entry.

## Structure
- Package pulse_stretcher_pkg holds the state enum (IDLE, HOLD, GAP) and a function computing counter width from HOLD_CYCLES/GAP_CYCLES.
- One sub-module, module_tick_counter: a loadable down-counter with load, value, and a zero flag, using the same asynchronous active-low reset.
- The FSM, pending counter and overflow flag live in the top module.

## Test plan
All scenarios use HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2 unless stated.
- Single event from IDLE → stretch_o high 4 cycles, low, busy_o high 6 cycles total, then IDLE; pending_o stays 0.
- Events on 3 consecutive cycles → pending_o peaks at 2; three 4-high/2-low pulses (18 busy cycles); pending_o returns to 0.
- Events on 5 consecutive cycles → pending_o saturates at 3 and overflow_o = 1 on the 5th event. Four pulses follow. clear_ovf_i clears overflow_o; clear plus overflow in the same cycle keeps it 1.
- Event in the last GAP cycle with pending_o = 0 → state goes HOLD on the next edge with no IDLE cycle; pending_o stays 0.
- RETRIGGER=1, events at cycles 0, 3, 6, 9 → stretch_o continuously high from cycle 1 to cycle 13; pending_o stays 0.
- reset_i asserted mid-HOLD (2 cycles in) with pending_o = 2 → all outputs 0 immediately, without waiting for a clock edge. After release, a new event produces a normal 4-cycle pulse.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
// The state enum and the counter-width rule live here so top and sub-module agree.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter must hold max(HOLD, GAP) - 1; never narrower than one bit.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/module_tick_counter.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
module module_tick_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)          value <= '0;
    else if (load)         value <= load_val;
    else if (value != '0)  value <= value - 1'b1;
  end

  assign zero = (value == '0);

endmodule

// File: rtl/module_pulse_stretcher.sv
// Turns single-cycle events into HOLD_CYCLES-wide pulses separated by at least
// GAP_CYCLES low, queueing events that arrive mid-pulse and flagging drops.
module module_pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              event_i,
  input  logic              clear_ovf_i,
  output logic              stretch_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int              CW       = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0]   HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic              load;
  logic [CW-1:0]     load_val;
  logic [CW-1:0]     cnt;
  logic              cnt_zero;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_set;
  logic              stretch_q;
  logic              cnt_unused;

  module_tick_counter #(.W(CW)) u_tick (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load     (load),
    .load_val (load_val),
    .value    (cnt),
    .zero     (cnt_zero)
  );

  // Only the zero flag steers the FSM; the raw count is observability only.
  assign cnt_unused = ^cnt;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = HOLD_LD;
    pend_d   = pend_q;
    ovf_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (event_i) begin
          state_d = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        if (event_i && RETRIGGER) begin
          load = 1'b1;
        end else begin
          if (event_i) begin
            if (pend_q == PEND_MAX) ovf_set = 1'b1;
            else                    pend_d  = pend_q + 1'b1;
          end
          if (cnt_zero) begin
            state_d  = GAP;
            load     = 1'b1;
            load_val = GAP_LD;
          end
        end
      end
      GAP: begin
        if (cnt_zero) begin
          // A same-cycle event replaces the queued one we consume here.
          if (pend_q != '0 || event_i) begin
            state_d = HOLD;
            load    = 1'b1;
            if (!event_i) pend_d = pend_q - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (event_i) begin
          if (pend_q == PEND_MAX) ovf_set = 1'b1;
          else                    pend_d  = pend_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      stretch_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      stretch_q <= (state_d == HOLD);
      if (ovf_set)          ovf_q <= 1'b1;
      else if (clear_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign stretch_o  = stretch_q;
  assign busy_o     = (state_q != IDLE);
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule
